// File: rtl/snake_body_tracker.sv
// -----------------------------------------------------------------------------
// snake_body_tracker
//
// Holds the snake body as a shift register of grid coordinates. On each step
// tick the snake advances one cell. The new head is checked against the walls,
// the snake's own body and the apple. The result is reported as single-cycle
// goodColl/badColl pulses for the score tracker downstream.
// A combinational occupancy query port serves the display renderer.
//
// Optional build macro:
//   SNAKE_WRAP_WALLS_EN - when defined, a head leaving one edge re-enters at
//                         the opposite edge and wall collisions never happen.
//                         When undefined, the grid edges are walls.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   start               pulse: start or restart a game (from IDLE or DEAD)
//   step                pulse: advance the snake one cell (RUN only)
//   dir_i[3:0]          one-hot direction request {up,down,left,right}
//   apple_x/apple_y     apple position
//   query_x/query_y     renderer query cell
//   query_hit           1 when the query cell holds a live segment
//   head_x/head_y       current head position
//   length              live segment count
//   goodColl/badColl    one-cycle pulses: apple eaten / wall or self hit
//   game_over           high while the game is in DEAD
// -----------------------------------------------------------------------------
module snake_body_tracker #(
    parameter  int GRID_W    = 8,
    parameter  int GRID_H    = 8,
    parameter  int MAX_LEN   = 16,
    parameter  int START_LEN = 2,
    localparam int XW        = $clog2(GRID_W),
    localparam int YW        = $clog2(GRID_H),
    localparam int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    input  logic [3:0]    dir_i,
    input  logic [XW-1:0] apple_x,
    input  logic [YW-1:0] apple_y,
    input  logic [XW-1:0] query_x,
    input  logic [YW-1:0] query_y,
    output logic          query_hit,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          goodColl,
    output logic          badColl,
    output logic          game_over
);

`ifdef SNAKE_WRAP_WALLS_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [XW-1:0] X_MAX     = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(GRID_H - 1);
    localparam logic [3:0]    DIR_RIGHT = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [XW-1:0] seg_x_d [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [YW-1:0] seg_y_d [MAX_LEN];
    logic [LW-1:0] len_q, len_d;
    // cur_dir is the direction of the last executed move (used for the
    // reverse check); next_dir is the most recently accepted request.
    logic [3:0]    cur_dir_q, cur_dir_d;
    logic [3:0]    next_dir_q, next_dir_d;
    logic          good_q, good_d;
    logic          bad_q, bad_d;

    // Initial body: horizontal line ending at the grid centre, head rightmost.
    logic [XW-1:0] init_x [MAX_LEN];
    logic [YW-1:0] init_y [MAX_LEN];

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_init
            if (gi < START_LEN) begin : g_live
                localparam int IX = GRID_W / 2 - gi;
                assign init_x[gi] = XW'(IX);
                assign init_y[gi] = YW'(GRID_H / 2);
            end else begin : g_dead
                assign init_x[gi] = '0;
                assign init_y[gi] = '0;
            end
        end
    endgenerate

    // ---------------- direction request filtering ----------------
    logic [3:0] rev_dir;
    logic       dir_ok;
    logic [3:0] eff_dir;

    assign rev_dir = {cur_dir_q[2], cur_dir_q[3], cur_dir_q[0], cur_dir_q[1]};
    assign dir_ok  = $onehot(dir_i) && !((dir_i == rev_dir) && (len_q > LW'(1)));
    // A request arriving together with step steers that very step.
    assign eff_dir = dir_ok ? dir_i : next_dir_q;

    // ---------------- next head and collision detection ----------------
    logic [XW-1:0] nh_x;
    logic [YW-1:0] nh_y;
    logic          at_edge;
    logic          wall_hit;
    logic          eat;
    logic          self_hit;

    // Edge detection uses the old coordinate, so no unsigned wrap is ever
    // mistaken for a legal move. nh already holds the wrapped coordinate.
    always_comb begin
        nh_x    = seg_x_q[0];
        nh_y    = seg_y_q[0];
        at_edge = 1'b0;
        if (eff_dir[0]) begin
            if (seg_x_q[0] == X_MAX) begin
                at_edge = 1'b1;
                nh_x    = '0;
            end else begin
                nh_x = seg_x_q[0] + 1'b1;
            end
        end else if (eff_dir[1]) begin
            if (seg_x_q[0] == '0) begin
                at_edge = 1'b1;
                nh_x    = X_MAX;
            end else begin
                nh_x = seg_x_q[0] - 1'b1;
            end
        end else if (eff_dir[2]) begin
            if (seg_y_q[0] == Y_MAX) begin
                at_edge = 1'b1;
                nh_y    = '0;
            end else begin
                nh_y = seg_y_q[0] + 1'b1;
            end
        end else if (eff_dir[3]) begin
            if (seg_y_q[0] == '0) begin
                at_edge = 1'b1;
                nh_y    = Y_MAX;
            end else begin
                nh_y = seg_y_q[0] - 1'b1;
            end
        end
    end

    assign wall_hit = at_edge && !WRAP;
    assign eat      = (nh_x == apple_x) && (nh_y == apple_y);

    // The tail normally vacates its cell on this move, so it is excluded.
    // On an eat the tail stays, so it is included.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((seg_x_q[i] == nh_x) && (seg_y_q[i] == nh_y) &&
                (((i + 1) < int'(len_q)) || (eat && (i < int'(len_q))))) begin
                self_hit = 1'b1;
            end
        end
    end

    // ---------------- renderer query ----------------
    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(len_q)) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y)) begin
                query_hit = 1'b1;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        len_d      = len_q;
        cur_dir_d  = cur_dir_q;
        next_dir_d = dir_ok ? dir_i : next_dir_q;
        good_d     = 1'b0;
        bad_d      = 1'b0;

        case (state_q)
            IDLE, DEAD: begin
                // A start pulse swallows any step arriving in the same cycle.
                if (start) begin
                    state_d    = RUN;
                    seg_x_d    = init_x;
                    seg_y_d    = init_y;
                    len_d      = LW'(START_LEN);
                    cur_dir_d  = DIR_RIGHT;
                    next_dir_d = DIR_RIGHT;
                end
            end
            RUN: begin
                if (step) begin
                    if (wall_hit || self_hit) begin
                        bad_d   = 1'b1;
                        state_d = DEAD;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x_d[i] = seg_x_q[i-1];
                            seg_y_d[i] = seg_y_q[i-1];
                        end
                        seg_x_d[0] = nh_x;
                        seg_y_d[0] = nh_y;
                        cur_dir_d  = eff_dir;
                        next_dir_d = eff_dir;
                        if (eat) begin
                            good_d = 1'b1;
                            if (len_q != LW'(MAX_LEN)) begin
                                len_d = len_q + 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            seg_x_q    <= init_x;
            seg_y_q    <= init_y;
            len_q      <= LW'(START_LEN);
            cur_dir_q  <= DIR_RIGHT;
            next_dir_q <= DIR_RIGHT;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            len_q      <= len_d;
            cur_dir_q  <= cur_dir_d;
            next_dir_q <= next_dir_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
        end
    end

    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign length    = len_q;
    assign goodColl  = good_q;
    assign badColl   = bad_q;
    assign game_over = (state_q == DEAD);

endmodule
